// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 4-bit processor.
// Drives the instruction ROM address (pc), captures the returned 8-bit
// instruction into ir, decodes it as opcode[7:4] / immediate[3:0] and
// executes it against accumulator A (acc) and operand register B (breg).
// Every instruction takes FETCH -> DECODE -> EXECUTE; HLT parks in HALT.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   reset        synchronous active-high reset
//   run          fetch enable; low stalls the core in FETCH
//   instruction  ROM data for address pc (combinational)
//   pc           program counter / ROM address
//   ir           instruction register
//   acc          accumulator A
//   breg         operand register B
//   carry        ADD carry / SUB borrow flag
//   zero         result-zero flag (LDI, ADD, SUB)
//   halted       high while parked in HALT
//   retire       one-cycle pulse after an instruction completes EXECUTE
//   illegal      one-cycle pulse with retire for undefined opcodes
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instruction,
  output logic [3:0] pc,
  output logic [7:0] ir,
  output logic [3:0] acc,
  output logic [3:0] breg,
  output logic       carry,
  output logic       zero,
  output logic       halted,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_NOP = 3'd0,
    C_LDI = 3'd1,
    C_ADD = 3'd2,
    C_SUB = 3'd3,
    C_JMP = 3'd4,
    C_HLT = 3'd5,
    C_ILL = 3'd6
  } opclass_t;

  state_t     state_q, state_d;
  opclass_t   cls_q, cls_d;
  logic [3:0] imm_q;
  logic [4:0] sum;
  logic [4:0] diff;

  // Opcode class from the captured instruction, latched in DECODE.
  always_comb begin
    cls_d = C_ILL;
    case (ir[7:4])
      4'b0000: cls_d = C_NOP;
      4'b0001: cls_d = C_LDI;
      4'b0010: cls_d = C_ADD;
      4'b0011: cls_d = C_SUB;
      4'b0100: cls_d = C_JMP;
      4'b1111: cls_d = C_HLT;
      default: cls_d = C_ILL;
    endcase
  end

  // 5-bit results: bit 4 is carry for ADD and borrow (A<B) for SUB.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, breg};
    diff = {1'b0, acc} - {1'b0, breg};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (run) state_d = S_DECODE;
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = (cls_q == C_HLT) ? S_HALT : S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      acc     <= '0;
      breg    <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      retire  <= 1'b0;
      illegal <= 1'b0;
      cls_q   <= C_NOP;
      imm_q   <= '0;
    end else begin
      retire  <= 1'b0;
      illegal <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (run) begin
            ir <= instruction;
            pc <= pc + 4'd1;
          end
        end
        S_DECODE: begin
          cls_q <= cls_d;
          imm_q <= ir[3:0];
        end
        S_EXECUTE: begin
          case (cls_q)
            C_LDI: begin
              breg <= acc;
              acc  <= imm_q;
              zero <= (imm_q == 4'd0);
            end
            C_ADD: begin
              acc   <= sum[3:0];
              carry <= sum[4];
              zero  <= (sum[3:0] == 4'd0);
            end
            C_SUB: begin
              acc   <= diff[3:0];
              carry <= diff[4];
              zero  <= (diff[3:0] == 4'd0);
            end
            C_JMP:   pc <= imm_q;
            default: ;
          endcase
          retire  <= (cls_q != C_HLT);
          illegal <= (cls_q == C_ILL);
        end
        default: ;
      endcase
    end
  end

  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] instruction;
  logic [3:0] pc;
  logic [7:0] ir;
  logic [3:0] acc;
  logic [3:0] breg;
  logic       carry;
  logic       zero;
  logic       halted;
  logic       retire;
  logic       illegal;

  logic [7:0] rom [16];

  control_unit dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .pc(pc), .ir(ir), .acc(acc), .breg(breg), .carry(carry), .zero(zero),
    .halted(halted), .retire(retire), .illegal(illegal)
  );

  assign instruction = rom[pc];

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rcount = 0;

  // Architectural reference state
  logic [3:0] m_pc, m_acc, m_b;
  logic       m_c, m_z, m_halt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (retire === 1'b1) rcount++;
  endtask

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_b = 0; m_c = 0; m_z = 0; m_halt = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"}, {4'd0, pc}, 8'd0);
    chk({tag, "_ir"}, ir, 8'd0);
    chk({tag, "_acc"}, {4'd0, acc}, 8'd0);
    chk({tag, "_breg"}, {4'd0, breg}, 8'd0);
    chk({tag, "_flags"}, {4'd0, carry, zero, halted, retire}, 8'd0);
    chk({tag, "_illegal"}, {7'd0, illegal}, 8'd0);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_reset_values(tag);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // One full instruction: fetch, decode, execute, then compare against
  // the architectural effect computed from the opcode.
  task automatic run_instr(input string tag, input bit drop_run);
    logic [7:0] f;
    logic [3:0] op, imm;
    int         res;
    f   = rom[m_pc];
    op  = f[7:4];
    imm = f[3:0];
    m_pc = m_pc + 4'd1;
    tick();
    if (drop_run) run = 1'b0;
    chk({tag, "_ir"}, ir, f);
    chk({tag, "_pcinc"}, {4'd0, pc}, {4'd0, m_pc});
    tick();
    chk({tag, "_noret_dec"}, {7'd0, retire}, 8'd0);
    tick();
    case (op)
      4'h1: begin m_b = m_acc; m_acc = imm; m_z = (imm == 0); end
      4'h2: begin
        res = int'(m_acc) + int'(m_b);
        m_c = (res > 15);
        m_acc = 4'(res % 16);
        m_z = (m_acc == 0);
      end
      4'h3: begin
        res = int'(m_acc) - int'(m_b);
        m_c = (res < 0);
        m_acc = 4'((res + 16) % 16);
        m_z = (m_acc == 0);
      end
      4'h4: m_pc = imm;
      4'hF: m_halt = 1;
      default: ;
    endcase
    if (m_halt) begin
      chk({tag, "_halted"}, {7'd0, halted}, 8'd1);
      chk({tag, "_hlt_noret"}, {7'd0, retire}, 8'd0);
    end else begin
      chk({tag, "_retire"}, {7'd0, retire}, 8'd1);
      chk({tag, "_illegal"}, {7'd0, illegal}, {7'd0, (op >= 4'h5 && op <= 4'hE)});
      chk({tag, "_halted"}, {7'd0, halted}, 8'd0);
    end
    chk({tag, "_acc"}, {4'd0, acc}, {4'd0, m_acc});
    chk({tag, "_breg"}, {4'd0, breg}, {4'd0, m_b});
    chk({tag, "_carry"}, {7'd0, carry}, {7'd0, m_c});
    chk({tag, "_zero"}, {7'd0, zero}, {7'd0, m_z});
    chk({tag, "_pc"}, {4'd0, pc}, {4'd0, m_pc});
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    clear_rom();
    model_reset();
    tick();
    reset = 1'b0;
    check_reset_values("rst0");

    // Basic program: LDI 5, LDI 3, ADD, SUB, NOP
    rom[0] = 8'h15; rom[1] = 8'h13; rom[2] = 8'h20; rom[3] = 8'h30; rom[4] = 8'h00;
    run = 1'b1;
    rcount = 0;
    for (int i = 0; i < 5; i++) run_instr("basic", 1'b0);
    chk("basic_acc_final", {4'd0, acc}, 8'd3);
    chk("basic_pc_final", {4'd0, pc}, 8'd5);
    chk("basic_retires", 8'(rcount), 8'd5);

    // Overflow then borrow-free SUB
    run = 1'b0;
    apply_reset("rst1");
    clear_rom();
    rom[0] = 8'h19; rom[1] = 8'h17; rom[2] = 8'h20; rom[3] = 8'h14; rom[4] = 8'h30;
    run = 1'b1;
    for (int i = 0; i < 3; i++) run_instr("ovf", 1'b0);
    chk("ovf_czacc", {carry, zero, 2'b00, acc}, 8'hC0);
    for (int i = 0; i < 2; i++) run_instr("sub0", 1'b0);
    chk("sub0_acc", {4'd0, acc}, 8'd4);

    // Borrow: A=3, B=5
    apply_reset("rst2");
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h13; rom[2] = 8'h30;
    for (int i = 0; i < 3; i++) run_instr("borrow", 1'b0);
    chk("borrow_czacc", {carry, zero, 2'b00, acc}, 8'h8E);

    // JMP 15 and pc wrap
    apply_reset("rst3");
    clear_rom();
    rom[0] = 8'h4F; rom[15] = 8'h00;
    run_instr("jmp", 1'b0);
    chk("jmp_pc", {4'd0, pc}, 8'd15);
    run_instr("wrap", 1'b0);
    chk("wrap_pc", {4'd0, pc}, 8'd0);
    run_instr("refetch0", 1'b0);

    // Stall: drop run during DECODE of LDI 6
    apply_reset("rst4");
    clear_rom();
    rom[0] = 8'h16; rom[1] = 8'h12;
    run = 1'b1;
    run_instr("stall", 1'b1);
    chk("stall_acc", {4'd0, acc}, 8'd6);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stall_pc_hold", {4'd0, pc}, 8'd1);
      chk("stall_ir_hold", ir, 8'h16);
      chk("stall_noret", {7'd0, retire}, 8'd0);
    end
    run = 1'b1;
    run_instr("resume", 1'b0);

    // Illegal opcode then HLT
    apply_reset("rst5");
    clear_rom();
    rom[0] = 8'h17; rom[1] = 8'hA3; rom[2] = 8'hF0;
    for (int i = 0; i < 3; i++) run_instr("illhlt", 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_frozen", {pc, acc}, {4'd3, 4'd7});
      chk("halt_state", {6'd0, halted, retire}, 8'b10);
    end
    apply_reset("rst_halt");
    run_instr("after_halt", 1'b0);

    // Reset during EXECUTE of ADD
    apply_reset("rst6");
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h13; rom[2] = 8'h20;
    run_instr("mid0", 1'b0);
    run_instr("mid1", 1'b0);
    tick();
    tick();
    apply_reset("rst_midexec");
    run_instr("restart", 1'b0);

    // Random programs without HLT
    apply_reset("rst7");
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'($urandom_range(0, 255));
      if (rom[i][7:4] == 4'hF) rom[i] = {4'h2, rom[i][3:0]};
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0;
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
          tick();
          chk("rand_stall_pc", {4'd0, pc}, {4'd0, m_pc});
        end
        run = 1'b1;
      end
      run_instr("rand", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
